segment_register_file_v2: RTL and testbench

Parametrised successor to the six-entry segment register file. It holds NUM_SEGS segment selectors of WIDTH bits. It has two read ports with optional write-to-read bypass, and a per-segment pending-write scoreboard so decode can stall on in-flight segment loads. It also produces the x86 side-effect pulses for SS writes (interrupt inhibit) and CS writes (fetch redirect). It sits between decode (reserve and read) and writeback (write).

---
 rtl/segment_register_file_v2.sv | 145 ++++++++++++++
 tb/tb_segment_register_file_v2.sv | 354 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/segment_register_file_v2.sv
// Segment selector register file: NUM_SEGS selectors, two bypassed read ports,
// per-segment pending-write counters and the SS/CS write side-effect pulses.
module segment_register_file_v2 #(
  parameter int               WIDTH       = 16,
  parameter int               NUM_SEGS    = 6,
  parameter int               MAX_PENDING = 3,
  parameter bit               BYPASS      = 1'b1,
  parameter logic [WIDTH-1:0] CS_RESET    = 16'hF000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                wr_en,
  input  logic [2:0]          wr_sel,
  input  logic [WIDTH-1:0]    wr_data,
  input  logic                rsv_en,
  input  logic [2:0]          rsv_sel,
  output logic                rsv_full,
  input  logic [2:0]          rd0_sel,
  input  logic [2:0]          rd1_sel,
  output logic [WIDTH-1:0]    rd0_data,
  output logic [WIDTH-1:0]    rd1_data,
  output logic                rd0_busy,
  output logic                rd1_busy,
  output logic [WIDTH-1:0]    cs_out,
  output logic [WIDTH-1:0]    ds_out,
  output logic [WIDTH-1:0]    es_out,
  output logic [WIDTH-1:0]    fs_out,
  output logic [WIDTH-1:0]    gs_out,
  output logic [WIDTH-1:0]    ss_out,
  output logic [NUM_SEGS-1:0] pending,
  output logic                ss_int_inhibit,
  output logic                cs_changed,
  output logic                sel_err
);

  localparam int             CW        = $clog2(MAX_PENDING + 1);
  localparam logic [CW-1:0]  MAX_CNT   = CW'(MAX_PENDING);
  localparam logic [CW-1:0]  ONE_CNT   = CW'(1);
  localparam logic [3:0]     SEG_LIMIT = 4'(NUM_SEGS);
  localparam logic [2:0]     SEL_CS    = 3'd1;
  localparam logic [2:0]     SEL_SS    = 3'd2;

  // Decode reserves a slot (rsv_en) only while rsv_full is low; writeback
  // later retires it with wr_en. There is no ready back to writeback: a write
  // is always accepted, and a write with no reservation is a plain update.
  logic wr_valid;
  logic rsv_valid;

  assign wr_valid  = wr_en  && ({1'b0, wr_sel}  < SEG_LIMIT);
  assign rsv_valid = rsv_en && ({1'b0, rsv_sel} < SEG_LIMIT);

  // All eight select codes are backed by a view; absent segments read as 0.
  logic [7:0][WIDTH-1:0] seg_view;
  logic [7:0][CW-1:0]    cnt_view;
  logic [7:0]            pend_view;

  assign rsv_full = (cnt_view[rsv_sel] == MAX_CNT);

  genvar g;
  generate
    for (g = 0; g < 8; g++) begin : g_seg
      if (g < NUM_SEGS) begin : g_live
        localparam logic [WIDTH-1:0] RST_VAL = (g == 1) ? CS_RESET : '0;
        localparam logic [2:0]       IDX     = 3'(g);

        logic [WIDTH-1:0] seg_q;
        logic [CW-1:0]    cnt_q;
        logic             wr_hit;
        logic             rsv_hit;

        assign wr_hit  = wr_valid && (wr_sel == IDX);
        assign rsv_hit = rsv_valid && (rsv_sel == IDX) && !rsv_full;

        always_ff @(posedge clk or negedge reset) begin
          if (!reset) begin
            seg_q <= RST_VAL;
            cnt_q <= '0;
          end else begin
            if (wr_hit) begin
              seg_q <= wr_data;
            end
            // A reserve and a retiring write in the same cycle cancel out.
            if (rsv_hit && !wr_hit) begin
              cnt_q <= cnt_q + ONE_CNT;
            end else if (wr_hit && !rsv_hit && (cnt_q != '0)) begin
              cnt_q <= cnt_q - ONE_CNT;
            end
          end
        end

        assign seg_view[g]  = seg_q;
        assign cnt_view[g]  = cnt_q;
        assign pend_view[g] = (cnt_q != '0);
      end else begin : g_absent
        assign seg_view[g]  = '0;
        assign cnt_view[g]  = '0;
        assign pend_view[g] = 1'b0;
      end
    end
  endgenerate

  assign pending = pend_view[NUM_SEGS-1:0];

  assign es_out = seg_view[0];
  assign cs_out = seg_view[1];
  assign ss_out = seg_view[2];
  assign ds_out = seg_view[3];
  assign fs_out = seg_view[4];
  assign gs_out = seg_view[5];

  // Read ports: a same-cycle write forwards its data, and if it retires the
  // last outstanding reservation the segment is no longer reported busy.
  logic rd0_hit;
  logic rd1_hit;

  assign rd0_hit = BYPASS && wr_valid && (wr_sel == rd0_sel);
  assign rd1_hit = BYPASS && wr_valid && (wr_sel == rd1_sel);

  assign rd0_data = rd0_hit ? wr_data : seg_view[rd0_sel];
  assign rd1_data = rd1_hit ? wr_data : seg_view[rd1_sel];

  assign rd0_busy = pend_view[rd0_sel] && !(rd0_hit && (cnt_view[rd0_sel] == ONE_CNT));
  assign rd1_busy = pend_view[rd1_sel] && !(rd1_hit && (cnt_view[rd1_sel] == ONE_CNT));

  logic ss_pulse_d;
  logic cs_pulse_d;
  logic sel_err_d;

  assign ss_pulse_d = wr_valid && (wr_sel == SEL_SS);
  assign cs_pulse_d = wr_valid && (wr_sel == SEL_CS);
  assign sel_err_d  = (wr_en && !wr_valid) || (rsv_en && !rsv_valid);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ss_int_inhibit <= 1'b0;
      cs_changed     <= 1'b0;
      sel_err        <= 1'b0;
    end else begin
      ss_int_inhibit <= ss_pulse_d;
      cs_changed     <= cs_pulse_d;
      sel_err        <= sel_err_d;
    end
  end

endmodule

// File: tb/tb_segment_register_file_v2.sv
// Bench for segment_register_file_v2: a reference model pushes expected values
// into exp_q as stimulus is driven; they are popped against the DUT outputs.
module tb_segment_register_file_v2;

  localparam int W = 16;

  logic          clk;
  logic          reset;
  logic          wr_en;
  logic [2:0]    wr_sel;
  logic [W-1:0]  wr_data;
  logic          rsv_en;
  logic [2:0]    rsv_sel;
  logic          rsv_full;
  logic [2:0]    rd0_sel;
  logic [2:0]    rd1_sel;
  logic [W-1:0]  rd0_data;
  logic [W-1:0]  rd1_data;
  logic          rd0_busy;
  logic          rd1_busy;
  logic [W-1:0]  cs_out;
  logic [W-1:0]  ds_out;
  logic [W-1:0]  es_out;
  logic [W-1:0]  fs_out;
  logic [W-1:0]  gs_out;
  logic [W-1:0]  ss_out;
  logic [5:0]    pending;
  logic          ss_int_inhibit;
  logic          cs_changed;
  logic          sel_err;

  segment_register_file_v2 dut (
    .clk            (clk),
    .reset          (reset),
    .wr_en          (wr_en),
    .wr_sel         (wr_sel),
    .wr_data        (wr_data),
    .rsv_en         (rsv_en),
    .rsv_sel        (rsv_sel),
    .rsv_full       (rsv_full),
    .rd0_sel        (rd0_sel),
    .rd1_sel        (rd1_sel),
    .rd0_data       (rd0_data),
    .rd1_data       (rd1_data),
    .rd0_busy       (rd0_busy),
    .rd1_busy       (rd1_busy),
    .cs_out         (cs_out),
    .ds_out         (ds_out),
    .es_out         (es_out),
    .fs_out         (fs_out),
    .gs_out         (gs_out),
    .ss_out         (ss_out),
    .pending        (pending),
    .ss_int_inhibit (ss_int_inhibit),
    .cs_changed     (cs_changed),
    .sel_err        (sel_err)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (got timeout, required finish)");
    $fatal(1);
  end

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  int n_checks = 0;
  int n_pass   = 0;

  logic [W-1:0] m_seg[8];
  int           m_cnt[8];

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h required %h", tag, obs, exp);
  endtask

  task automatic sb_push(input logic [W-1:0] v);
    exp_q.push_back(v);
  endtask

  task automatic sb_check(input string tag, input logic [W-1:0] obs);
    if (exp_q.size() == 0) begin
      n_checks++;
      $display("FAIL %s: got %h required an expected entry (queue empty)", tag, obs);
    end else begin
      check(tag, obs, exp_q.pop_front());
    end
  endtask

  function automatic logic [W-1:0] get_out(input int idx);
    case (idx)
      0: return es_out;
      1: return cs_out;
      2: return ss_out;
      3: return ds_out;
      4: return fs_out;
      5: return gs_out;
      default: return '0;
    endcase
  endfunction

  function automatic logic [W-1:0] exp_pending();
    logic [W-1:0] p;
    p = '0;
    for (int i = 0; i < 6; i++) p[i] = (m_cnt[i] != 0);
    return p;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 8; i++) begin
      m_seg[i] = '0;
      m_cnt[i] = 0;
    end
    m_seg[1] = 16'hF000;
  endtask

  task automatic check_all_outs(input string tag);
    for (int i = 0; i < 6; i++) begin
      sb_push(m_seg[i]);
      sb_check(tag, get_out(i));
    end
  endtask

  // ---------------- drivers ----------------
  // Inputs change 1 ns after a rising edge; the task returns 1 ns after the
  // edge that consumed them, so registered results are observable on return.
  task automatic do_write(input logic [2:0] sel, input logic [W-1:0] data);
    wr_en = 1'b1;
    wr_sel = sel;
    wr_data = data;
    if (sel < 6) begin
      m_seg[sel] = data;
      if (m_cnt[sel] > 0) m_cnt[sel]--;
    end
    @(posedge clk);
    #1;
    wr_en = 1'b0;
  endtask

  task automatic do_rsv(input logic [2:0] sel);
    rsv_en = 1'b1;
    rsv_sel = sel;
    if (sel < 6 && m_cnt[sel] < 3) m_cnt[sel]++;
    @(posedge clk);
    #1;
    rsv_en = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // ---------------- stimulus ----------------
  logic [2:0]   wsel[6];
  logic [W-1:0] wdat[6];

  initial begin
    reset = 1'b0;
    wr_en = 1'b0; wr_sel = '0; wr_data = '0;
    rsv_en = 1'b0; rsv_sel = '0;
    rd0_sel = '0; rd1_sel = '0;
    model_reset();

    // Reset values while reset is held low.
    #10;
    check_all_outs("reset_out");
    check("reset_pending", {10'b0, pending}, '0);
    check("reset_ss_inh", {15'b0, ss_int_inhibit}, '0);
    check("reset_cs_chg", {15'b0, cs_changed}, '0);
    check("reset_sel_err", {15'b0, sel_err}, '0);
    check("reset_rsv_full", {15'b0, rsv_full}, '0);
    #2 reset = 1'b1;
    @(posedge clk);
    #1;

    // Write each segment in order; value appears one cycle later.
    wsel = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5};
    wdat = '{16'hC345, 16'hA123, 16'hF678, 16'hB234, 16'hD456, 16'hE567};
    for (int i = 0; i < 6; i++) begin
      do_write(wsel[i], wdat[i]);
      sb_push(wdat[i]);
      sb_check("wr_out", get_out(int'(wsel[i])));
    end

    // Idle with junk data on the bus: nothing changes.
    wr_data = 16'hFFFF;
    idle(2);
    check_all_outs("hold_out");
    check("hold_pending", {10'b0, pending}, exp_pending());

    // Both read ports against the model, also on the same segment.
    for (int i = 0; i < 6; i++) begin
      rd0_sel = 3'(i);
      rd1_sel = 3'(5 - i);
      #1;
      sb_push(m_seg[i]);
      sb_check("rd0_data", rd0_data);
      sb_push(m_seg[5 - i]);
      sb_check("rd1_data", rd1_data);
    end
    rd0_sel = 3'd3; rd1_sel = 3'd3;
    #1;
    check("rd_same", rd1_data, rd0_data);

    // SS write: one-cycle interrupt inhibit, no CS pulse.
    do_write(3'd2, 16'h1234);
    check("ss_pulse", {15'b0, ss_int_inhibit}, 16'd1);
    check("ss_no_cs", {15'b0, cs_changed}, 16'd0);
    sb_push(16'h1234);
    sb_check("ss_out", ss_out);
    idle(1);
    check("ss_pulse_end", {15'b0, ss_int_inhibit}, 16'd0);

    // Back-to-back SS writes hold the pulse high.
    do_write(3'd2, 16'h2222);
    check("ss_b2b_1", {15'b0, ss_int_inhibit}, 16'd1);
    do_write(3'd2, 16'h3333);
    check("ss_b2b_2", {15'b0, ss_int_inhibit}, 16'd1);
    idle(1);
    check("ss_b2b_end", {15'b0, ss_int_inhibit}, 16'd0);

    // CS write: one-cycle redirect pulse.
    do_write(3'd1, 16'h0800);
    check("cs_pulse", {15'b0, cs_changed}, 16'd1);
    check("cs_no_ss", {15'b0, ss_int_inhibit}, 16'd0);
    sb_push(16'h0800);
    sb_check("cs_out", cs_out);
    idle(1);
    check("cs_pulse_end", {15'b0, cs_changed}, 16'd0);

    // Reserve DS up to the limit, then one more which must be dropped.
    rd0_sel = 3'd3;
    rsv_sel = 3'd3;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("rsv_not_full", {15'b0, rsv_full}, 16'd0);
      do_rsv(3'd3);
    end
    check("rsv_full", {15'b0, rsv_full}, 16'd1);
    check("rsv_pending", {10'b0, pending}, exp_pending());
    do_rsv(3'd3);
    check("rsv_drop_full", {15'b0, rsv_full}, 16'd1);
    check("rsv_drop_pend", {10'b0, pending}, exp_pending());

    // Retire three writes; busy stays up until the last.
    for (int i = 0; i < 3; i++) begin
      #1;
      check("busy_before_wr", {15'b0, rd0_busy}, 16'd1);
      do_write(3'd3, 16'(16'h4000 + i));
    end
    check("busy_fall", {15'b0, rd0_busy}, 16'd0);
    check("drain_pending", {10'b0, pending}, exp_pending());

    // Same-cycle reserve and write with count 1: count unchanged.
    do_rsv(3'd3);
    rsv_en = 1'b1; rsv_sel = 3'd3;
    wr_en = 1'b1; wr_sel = 3'd3; wr_data = 16'h7777;
    m_seg[3] = 16'h7777;
    @(posedge clk);
    #1;
    rsv_en = 1'b0; wr_en = 1'b0;
    check("rsv_wr_same", {10'b0, pending}, exp_pending());
    do_write(3'd3, 16'h7778);
    check("rsv_wr_drain", {10'b0, pending}, exp_pending());

    // Same-cycle reserve and write with count 0: stays 0.
    rsv_en = 1'b1; rsv_sel = 3'd3;
    wr_en = 1'b1; wr_sel = 3'd3; wr_data = 16'h7779;
    m_seg[3] = 16'h7779;
    @(posedge clk);
    #1;
    rsv_en = 1'b0; wr_en = 1'b0;
    check("rsv_wr_zero", {10'b0, pending}, exp_pending());

    // Bypass with count 2: data forwards, busy remains.
    do_rsv(3'd3);
    do_rsv(3'd3);
    rd0_sel = 3'd3; rd1_sel = 3'd3;
    wr_en = 1'b1; wr_sel = 3'd3; wr_data = 16'h6666;
    #1;
    check("byp2_data", rd1_data, 16'h6666);
    check("byp2_busy", {15'b0, rd1_busy}, 16'd1);
    m_seg[3] = 16'h6666; m_cnt[3]--;
    @(posedge clk);
    #1;
    wr_en = 1'b0;
    #1;
    check("byp1_busy_pre", {15'b0, rd1_busy}, 16'd1);

    // Bypass with count 1: data forwards and busy drops in the same cycle.
    wr_en = 1'b1; wr_sel = 3'd3; wr_data = 16'h5555;
    #1;
    check("byp_rd1_data", rd1_data, 16'h5555);
    check("byp_rd1_busy", {15'b0, rd1_busy}, 16'd0);
    check("byp_rd0_data", rd0_data, 16'h5555);
    check("byp_rd0_busy", {15'b0, rd0_busy}, 16'd0);
    m_seg[3] = 16'h5555; m_cnt[3]--;
    @(posedge clk);
    #1;
    wr_en = 1'b0;
    sb_push(16'h5555);
    sb_check("byp_ds_out", ds_out);
    check("byp_pending", {10'b0, pending}, exp_pending());

    // Invalid selects: ignored, sel_err pulses, high selects read 0.
    do_write(3'd7, 16'hABCD);
    check("sel_err_wr", {15'b0, sel_err}, 16'd1);
    check_all_outs("bad_wr_out");
    idle(1);
    check("sel_err_end", {15'b0, sel_err}, 16'd0);
    do_rsv(3'd6);
    check("sel_err_rsv", {15'b0, sel_err}, 16'd1);
    check("bad_rsv_pend", {10'b0, pending}, exp_pending());
    rd0_sel = 3'd6; rd1_sel = 3'd7;
    #1;
    check("rd_hi_data0", rd0_data, 16'h0000);
    check("rd_hi_data1", rd1_data, 16'h0000);
    check("rd_hi_busy0", {15'b0, rd0_busy}, 16'd0);

    // Asynchronous reset mid-run, away from any clock edge.
    do_rsv(3'd4);
    do_write(3'd2, 16'h9999);
    check("pre_rst_pend", {10'b0, pending}, exp_pending());
    check("pre_rst_ss", {15'b0, ss_int_inhibit}, 16'd1);
    #2;
    reset = 1'b0;
    model_reset();
    #1;
    check_all_outs("async_rst_out");
    check("async_rst_pend", {10'b0, pending}, '0);
    check("async_rst_ss", {15'b0, ss_int_inhibit}, '0);
    #2 reset = 1'b1;
    idle(1);
    check_all_outs("post_rst_out");

    if (exp_q.size() != 0) begin
      n_checks++;
      $display("FAIL sb_drain: got %0d leftover entries required 0", exp_q.size());
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
